// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX->MEM pipeline register with stall/bubble/flush handling and MADD/MSUB state feedback.
// Optional feature macro: STALL_PERF_EN adds perf_stall / perf_bubble 16-bit saturating counters.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   ctrl, flush           stall vector (bit STALL_LO = EX stalled, STALL_LO+1 = MEM stalled), sync flush
//   ex_*                  instruction fields from EX
//   acc_i, cnt_i          multi-cycle partial product and step count from EX
//   mem_*                 registered fields to MEM
//   acc_o, cnt_o          multi-cycle state fed back to EX
//   perf_stall/bubble     hold-cycle and bubble counters (STALL_PERF_EN only)
module ex_mem_stage_reg #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int OP_W     = 8,
    parameter int CTRL_W   = 6,
    parameter int STALL_LO = 3,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CTRL_W-1:0]   ctrl,
    input  logic                flush,
    input  logic                ex_valid,
    input  logic [RADDR_W-1:0]  ex_waddr,
    input  logic                ex_wen,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_hilo_we,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [OP_W-1:0]     ex_aluop,
    input  logic [DATA_W-1:0]   ex_mem_addr,
    input  logic [DATA_W-1:0]   ex_reg_op2,
    input  logic [2*DATA_W-1:0] acc_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic                mem_valid,
    output logic [RADDR_W-1:0]  mem_waddr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_hilo_we,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic [OP_W-1:0]     mem_aluop,
    output logic [DATA_W-1:0]   mem_mem_addr,
    output logic [DATA_W-1:0]   mem_reg_op2,
    output logic [2*DATA_W-1:0] acc_o,
    output logic [CNT_W-1:0]    cnt_o
`ifdef STALL_PERF_EN
    ,
    output logic [15:0]         perf_stall,
    output logic [15:0]         perf_bubble
`endif
);
    logic ex_stall, mem_stall;
    logic unused_ctrl;
    assign ex_stall    = ctrl[STALL_LO];
    assign mem_stall   = ctrl[STALL_LO+1];
    assign unused_ctrl = ^ctrl;
    // Flush and bubble both load zeros into the MEM fields; only bubble keeps the
    // multi-cycle state alive so EX can resume the MADD/MSUB after the stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            mem_valid    <= 1'b0;
            mem_waddr    <= '0;
            mem_wen      <= 1'b0;
            mem_wdata    <= '0;
            mem_hilo_we  <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg_op2  <= '0;
            acc_o        <= '0;
            cnt_o        <= '0;
        end else if (!ex_stall) begin
            mem_valid    <= ex_valid;
            mem_waddr    <= ex_waddr;
            mem_wen      <= ex_wen & ex_valid;
            mem_wdata    <= ex_wdata;
            mem_hilo_we  <= ex_hilo_we & ex_valid;
            mem_hi       <= ex_hi;
            mem_lo       <= ex_lo;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_reg_op2  <= ex_reg_op2;
            acc_o        <= '0;
            cnt_o        <= '0;
        end else if (!mem_stall) begin
            mem_valid    <= 1'b0;
            mem_waddr    <= '0;
            mem_wen      <= 1'b0;
            mem_wdata    <= '0;
            mem_hilo_we  <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg_op2  <= '0;
            acc_o        <= acc_i;
            cnt_o        <= cnt_i;
        end
    end
`ifdef STALL_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall  <= '0;
            perf_bubble <= '0;
        end else if (!flush && ex_stall) begin
            if (mem_stall && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
            if (!mem_stall && perf_bubble != 16'hFFFF)
                perf_bubble <= perf_bubble + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb_ex_mem_stage_reg: directed self-checking bench for ex_mem_stage_reg.
module tb_ex_mem_stage_reg;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  ctrl;
    logic        flush;
    logic        ex_valid, ex_wen, ex_hilo_we;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg_op2;
    logic [7:0]  ex_aluop;
    logic [63:0] acc_i, acc_o;
    logic [1:0]  cnt_i, cnt_o;
    logic        mem_valid, mem_wen, mem_hilo_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg_op2;
    logic [7:0]  mem_aluop;
    logic [175:0] ob;
    int checks = 0;
    int errors = 0;
`ifdef STALL_PERF_EN
    logic [15:0] perf_stall, perf_bubble;
`endif

    ex_mem_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .flush(flush),
        .ex_valid(ex_valid), .ex_waddr(ex_waddr), .ex_wen(ex_wen), .ex_wdata(ex_wdata),
        .ex_hilo_we(ex_hilo_we), .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop),
        .ex_mem_addr(ex_mem_addr), .ex_reg_op2(ex_reg_op2), .acc_i(acc_i), .cnt_i(cnt_i),
        .mem_valid(mem_valid), .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_hilo_we(mem_hilo_we), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_reg_op2(mem_reg_op2), .acc_o(acc_o), .cnt_o(cnt_o)
`ifdef STALL_PERF_EN
        , .perf_stall(perf_stall), .perf_bubble(perf_bubble)
`endif
    );

    always #5 clk = ~clk;

    assign ob = {mem_valid, mem_waddr, mem_wen, mem_wdata, mem_hilo_we, mem_hi, mem_lo,
                 mem_aluop, mem_mem_addr, mem_reg_op2};

    function automatic logic [175:0] mk(input logic v, input logic [4:0] wa, input logic we,
        input logic [31:0] wd, input logic hwe, input logic [31:0] hi, input logic [31:0] lo,
        input logic [7:0] op, input logic [31:0] ad, input logic [31:0] o2);
        return {v, wa, we, wd, hwe, hi, lo, op, ad, o2};
    endfunction

    task automatic set_ex(input logic v, input logic [4:0] wa, input logic we,
        input logic [31:0] wd, input logic hwe, input logic [31:0] hi, input logic [31:0] lo,
        input logic [7:0] op, input logic [31:0] ad, input logic [31:0] o2);
        ex_valid = v; ex_waddr = wa; ex_wen = we; ex_wdata = wd; ex_hilo_we = hwe;
        ex_hi = hi; ex_lo = lo; ex_aluop = op; ex_mem_addr = ad; ex_reg_op2 = o2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++;
        if ({ob, acc_o, cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_state got %h/%h/%h want 0", ob, acc_o, cnt_o);
        end
        rst_n = 1'b1;
        ctrl = 6'b000000;
        set_ex(1, 5'd3, 1, 32'h11112222, 1, 32'h3, 32'h4, 8'h21, 32'h40, 32'h50);
        tick;
        ctrl = 6'b001000; acc_i = 64'h99; cnt_i = 2'd3;
        tick;
        ctrl = 6'b011000;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ob, acc_o, cnt_o} !== '0) begin
            errors++;
            $display("FAIL async_reset got %h/%h/%h want 0", ob, acc_o, cnt_o);
        end
        #1 rst_n = 1'b1;
        ctrl = 6'b000000;
    endtask

    task automatic test_advance;
        logic [175:0] e;
        set_ex(1, 5'd7, 1, 32'hDEADBEEF, 1, 32'h11111111, 32'h22222222, 8'h23, 32'h1000, 32'h55);
        acc_i = 64'h77; cnt_i = 2'd2;
        tick;
        e = mk(1, 5'd7, 1, 32'hDEADBEEF, 1, 32'h11111111, 32'h22222222, 8'h23, 32'h1000, 32'h55);
        checks++;
        if ({ob, acc_o, cnt_o} !== {e, 64'h0, 2'd0}) begin
            errors++;
            $display("FAIL advance1 got %h/%h/%h want %h/0/0", ob, acc_o, cnt_o, e);
        end
        set_ex(1, 5'd31, 0, 32'h0, 0, 32'hFFFFFFFF, 32'h0, 8'hFF, 32'hFFFFFFFC, 32'h80000000);
        tick;
        e = mk(1, 5'd31, 0, 32'h0, 0, 32'hFFFFFFFF, 32'h0, 8'hFF, 32'hFFFFFFFC, 32'h80000000);
        checks++;
        if (ob !== e) begin
            errors++;
            $display("FAIL advance2 got %h want %h", ob, e);
        end
    endtask

    task automatic test_bubble;
        logic [175:0] e;
        ctrl = 6'b001000;
        set_ex(1, 5'd3, 1, 32'hCAFEF00D, 1, 32'h5, 32'h6, 8'h2B, 32'h2000, 32'h77);
        acc_i = 64'h1234; cnt_i = 2'd1;
        tick;
        checks++;
        if ({ob, acc_o, cnt_o} !== {176'h0, 64'h1234, 2'd1}) begin
            errors++;
            $display("FAIL bubble got %h/%h/%h want 0/1234/1", ob, acc_o, cnt_o);
        end
        ctrl = 6'b000000;
        tick;
        e = mk(1, 5'd3, 1, 32'hCAFEF00D, 1, 32'h5, 32'h6, 8'h2B, 32'h2000, 32'h77);
        checks++;
        if ({ob, acc_o, cnt_o} !== {e, 64'h0, 2'd0}) begin
            errors++;
            $display("FAIL bubble_release got %h/%h/%h want %h/0/0", ob, acc_o, cnt_o, e);
        end
    endtask

    task automatic test_hold;
        logic [175:0] e;
`ifdef STALL_PERF_EN
        logic [15:0] base;
`endif
        ctrl = 6'b000000;
        set_ex(1, 5'd12, 1, 32'hA5A5A5A5, 0, 32'h9, 32'hA, 8'h24, 32'h3000, 32'h88);
        tick;
        e = mk(1, 5'd12, 1, 32'hA5A5A5A5, 0, 32'h9, 32'hA, 8'h24, 32'h3000, 32'h88);
`ifdef STALL_PERF_EN
        base = perf_stall;
`endif
        ctrl = 6'b011000;
        set_ex(1, 5'd1, 0, 32'h5A5A5A5A, 1, 32'h1, 32'h2, 8'h11, 32'h4, 32'h5);
        acc_i = 64'hFFFF_0000_FFFF_0000; cnt_i = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if ({ob, acc_o, cnt_o} !== {e, 64'h0, 2'd0}) begin
                errors++;
                $display("FAIL hold%0d got %h/%h/%h want %h/0/0", i, ob, acc_o, cnt_o, e);
            end
        end
`ifdef STALL_PERF_EN
        checks++;
        if (perf_stall - base !== 16'd3) begin
            errors++;
            $display("FAIL perf_stall got %0d want %0d", perf_stall, base + 16'd3);
        end
`endif
    endtask

    task automatic test_flush;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        checks++;
        if ({ob, acc_o, cnt_o} !== '0) begin
            errors++;
            $display("FAIL flush got %h/%h/%h want 0", ob, acc_o, cnt_o);
        end
    endtask

    task automatic test_invalid;
        logic [175:0] e;
        ctrl = 6'b000000;
        set_ex(0, 5'd9, 1, 32'h12345678, 1, 32'hAB, 32'hCD, 8'h2C, 32'h44, 32'h66);
        tick;
        e = mk(0, 5'd9, 0, 32'h12345678, 0, 32'hAB, 32'hCD, 8'h2C, 32'h44, 32'h66);
        checks++;
        if (ob !== e) begin
            errors++;
            $display("FAIL invalid_capture got %h want %h", ob, e);
        end
    endtask

    task automatic test_back_to_back;
        logic [175:0] e;
        ctrl = 6'b001000; acc_i = 64'hABCDEF0123456789; cnt_i = 2'd2;
        tick;
        ctrl = 6'b011000; acc_i = 64'h1; cnt_i = 2'd0;
        tick;
        checks++;
        if ({acc_o, cnt_o} !== {64'hABCDEF0123456789, 2'd2}) begin
            errors++;
            $display("FAIL hold_acc got %h/%h want abcdef0123456789/2", acc_o, cnt_o);
        end
        ctrl = 6'b001000; flush = 1'b1; acc_i = 64'h5;
        tick;
        flush = 1'b0;
        checks++;
        if ({acc_o, cnt_o} !== '0) begin
            errors++;
            $display("FAIL flush_over_bubble got %h/%h want 0/0", acc_o, cnt_o);
        end
        acc_i = 64'h77; cnt_i = 2'd3;
        tick;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({acc_o, cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_stall got %h/%h want 0/0", acc_o, cnt_o);
        end
        rst_n = 1'b1;
        ctrl = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            set_ex(1, 5'(i + 20), 1, 32'h100 * (i + 1), i[0], 32'(i), 32'(i + 1), 8'(i + 8'h30),
                   32'h8000 + 32'(4 * i), 32'hF0 + 32'(i));
            tick;
            e = mk(1, 5'(i + 20), 1, 32'h100 * (i + 1), i[0], 32'(i), 32'(i + 1), 8'(i + 8'h30),
                   32'h8000 + 32'(4 * i), 32'hF0 + 32'(i));
            checks++;
            if (ob !== e) begin
                errors++;
                $display("FAIL b2b%0d got %h want %h", i, ob, e);
            end
        end
    endtask

`ifdef STALL_PERF_EN
    task automatic test_perf_sat;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        ctrl = 6'b001000;
        for (int i = 0; i < 65537; i++) tick;
        checks++;
        if ({perf_bubble, perf_stall} !== {16'hFFFF, 16'h0}) begin
            errors++;
            $display("FAIL perf_sat got %h/%h want ffff/0000", perf_bubble, perf_stall);
        end
        ctrl = 6'b000000;
    endtask
`endif

    initial begin
        rst_n = 1'b0; ctrl = '0; flush = 1'b0; acc_i = '0; cnt_i = '0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        test_reset;
        test_advance;
        test_bubble;
        test_hold;
        test_flush;
        test_invalid;
        test_back_to_back;
`ifdef STALL_PERF_EN
        test_perf_sat;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
